pc_seq: RTL and testbench

Fetch sequencer for the program counter. Owns the PC register, runs the request/grant/response handshake to instruction memory, and hands one fetched instruction at a time to decode. Applies control-flow redirects (trap, mret, branch/jump) with fixed priority and discards wrong-path responses. Sits between the redirect sources in execute/CSR and the instruction memory port.

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_redirect_mux.sv | 33 +++
 rtl/pc_seq.sv | 140 ++++++++++++++
 tb/tb_pc_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared fetch-sequencer definitions.
// Holds the default datapath width and reset vector, the fetch FSM state
// encoding, and the alignment rule applied to every redirect target.
package pc_seq_pkg;

  // Default PC / instruction width and the PC loaded by reset.
  localparam int                CPU_WIDTH_DEF = 32;
  localparam logic [31:0]       RESET_VEC_DEF = 32'h0000_0000;

  // Number of low PC bits that are forced to zero on a redirect
  // (instructions are word aligned).
  localparam int                ALIGN_BITS    = 2;

  // Fetch FSM state encoding.
  localparam logic [1:0]        ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0]        ST_REQ_ENC    = 2'd1;
  localparam logic [1:0]        ST_WAIT_ENC   = 2'd2;
  localparam logic [1:0]        ST_HOLD_ENC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,   // coming out of reset, raising ena
    REQ  = ST_REQ_ENC,    // imem_req high, waiting for imem_gnt
    WAIT = ST_WAIT_ENC,   // request accepted, waiting for imem_rvalid
    HOLD = ST_HOLD_ENC    // instruction presented to decode
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: combinational selection of the control-flow redirect.
// Priority is trap > mret > branch/jump; only the winning target is used and
// its low bits are cleared so the fetch address is always word aligned.
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         trap,
  input  logic [W-1:0] trap_vec,
  input  logic         mret,
  input  logic [W-1:0] mepc,
  input  logic         br_taken,
  input  logic [W-1:0] br_target,
  output logic         redir_vld,
  output logic [W-1:0] redir_pc
);

  logic [W-1:0] raw_target;

  // Pick the highest-priority requested target, then align it.
  always_comb begin
    raw_target = br_target;
    if (trap) begin
      raw_target = trap_vec;
    end else if (mret) begin
      raw_target = mepc;
    end
    redir_vld = trap | mret | br_taken;
    redir_pc  = {raw_target[W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: fetch sequencer. Owns the PC, runs the req/gnt/rvalid handshake to
// instruction memory and holds one fetched instruction for decode at a time.
// Redirects arriving while a fetch is in flight are remembered and the
// wrong-path response is dropped when it comes back.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int                   CPU_WIDTH = CPU_WIDTH_DEF,
  parameter logic [CPU_WIDTH-1:0] RESET_VEC = CPU_WIDTH'(RESET_VEC_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ena,
  input  logic                 trap,
  input  logic [CPU_WIDTH-1:0] trap_vec,
  input  logic                 mret,
  input  logic [CPU_WIDTH-1:0] mepc,
  input  logic                 br_taken,
  input  logic [CPU_WIDTH-1:0] br_target,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [CPU_WIDTH-1:0] imem_rdata,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] curr_pc
);

  pc_state_e            state_reg;
  logic                 kill_reg;      // in-flight response is wrong-path
  logic                 pend_vld_reg;  // redirect seen while still requesting
  logic [CPU_WIDTH-1:0] pend_pc_reg;   // latest redirect target (last wins)

  logic                 redir_vld;
  logic [CPU_WIDTH-1:0] redir_pc;

  pc_redirect_mux #(
    .W (CPU_WIDTH)
  ) u_redirect_mux (
    .trap      (trap),
    .trap_vec  (trap_vec),
    .mret      (mret),
    .mepc      (mepc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .redir_vld (redir_vld),
    .redir_pc  (redir_pc)
  );

  // The fetch address is the PC register itself, so it only moves when the
  // FSM decides to start a new fetch and stays put while a request is open.
  assign imem_addr = curr_pc;

  // Fetch FSM: all outputs are registered here, none depend on inputs
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      curr_pc      <= RESET_VEC;
      ena          <= 1'b0;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      inst         <= '0;
      kill_reg     <= 1'b0;
      pend_vld_reg <= 1'b0;
      pend_pc_reg  <= '0;
    end else begin
      unique case (state_reg)
        // First edge raises ena; the next edge starts the first request, so
        // imem_req trails ena by one cycle. Redirects are not looked at here.
        IDLE: begin
          if (!ena) begin
            ena <= 1'b1;
          end else begin
            imem_req  <= 1'b1;
            state_reg <= REQ;
          end
        end

        // Address held until grant. A redirect is only recorded; the granted
        // fetch then becomes wrong-path and is killed in WAIT.
        REQ: begin
          if (redir_vld) begin
            pend_pc_reg  <= redir_pc;
            pend_vld_reg <= 1'b1;
          end
          if (imem_gnt) begin
            imem_req  <= 1'b0;
            kill_reg  <= pend_vld_reg | redir_vld;
            state_reg <= WAIT;
          end
        end

        // Response either becomes the held instruction or is thrown away,
        // in which case the fetch restarts at the newest redirect target.
        WAIT: begin
          if (imem_rvalid) begin
            if (!kill_reg && !redir_vld) begin
              inst       <= imem_rdata;
              inst_valid <= 1'b1;
              state_reg  <= HOLD;
            end else begin
              curr_pc      <= redir_vld ? redir_pc : pend_pc_reg;
              kill_reg     <= 1'b0;
              pend_vld_reg <= 1'b0;
              imem_req     <= 1'b1;
              state_reg    <= REQ;
            end
          end else if (redir_vld) begin
            kill_reg    <= 1'b1;
            pend_pc_reg <= redir_pc;
          end
        end

        // Present the instruction until decode takes it. A redirect flushes
        // it even if decode accepts in the same cycle.
        HOLD: begin
          if (redir_vld) begin
            inst_valid <= 1'b0;
            curr_pc    <= redir_pc;
            imem_req   <= 1'b1;
            state_reg  <= REQ;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            curr_pc    <= curr_pc + CPU_WIDTH'(4);
            imem_req   <= 1'b1;
            state_reg  <= REQ;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized bench for the fetch sequencer. A transaction-level
// reference tracks which address the next fetch must use, whether the fetch
// window saw a redirect (response must be dropped) and which instruction
// decode should see; a small memory model answers grants after 1..3 cycles.
module tb_pc_seq;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        trap;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] curr_pc;

  int checks = 0;
  int errors = 0;

  // Reference state (transaction level).
  logic        m_fetch;   // a fetch window is open (requesting or in flight)
  logic        m_req;     // request not yet granted
  logic        m_out;     // granted, response outstanding
  int          m_lat;     // cycles until memory answers
  logic [31:0] m_faddr;   // address of the current fetch
  logic        m_pend;    // redirect seen during this fetch window
  logic [31:0] m_ptgt;    // newest redirect target seen in the window
  logic        m_hold;    // decode should see a valid instruction
  logic [31:0] m_inst;
  logic [31:0] m_hpc;

  pc_seq #(
    .CPU_WIDTH (32),
    .RESET_VEC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .trap        (trap),
    .trap_vec    (trap_vec),
    .mret        (mret),
    .mepc        (mepc),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .curr_pc     (curr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick_tgt();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'hFFFF_FFFF;
      1:       v = $urandom;
      2:       v = 32'h0000_0103;
      default: v = {20'h0, 12'($urandom)};
    endcase
    return v;
  endfunction

  task automatic start_fetch(input logic [31:0] a);
    m_fetch = 1'b1;
    m_req   = 1'b1;
    m_out   = 1'b0;
    m_faddr = a;
    m_pend  = 1'b0;
  endtask

  // Assert reset, check reset values without any clock edge, release, check
  // the ena -> imem_req startup sequence and arm the reference model.
  task automatic reset_start();
    rst         = 1'b1;
    trap        = 1'b0;
    mret        = 1'b0;
    br_taken    = 1'b0;
    trap_vec    = '0;
    mepc        = '0;
    br_target   = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    #1;
    check_eq("rst_ena", ena, 1'b0);
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_curr_pc", curr_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("start_ena", ena, 1'b1);
    check_eq("start_req_low", imem_req, 1'b0);
    @(negedge clk);
    m_hold = 1'b0;
    start_fetch(32'h0000_0000);
  endtask

  // One clock cycle: compare outputs with the model, drive random inputs,
  // then advance the model using this cycle's inputs.
  task automatic step();
    logic        redir;
    logic [31:0] tgt;

    check_eq("ena", ena, 1'b1);
    check_eq("imem_req", imem_req, m_req);
    check_eq("inst_valid", inst_valid, m_hold);
    if (m_fetch) check_eq("imem_addr", imem_addr, m_faddr);
    if (m_hold) begin
      check_eq("inst", inst, m_inst);
      check_eq("curr_pc_hold", curr_pc, m_hpc);
    end

    imem_gnt    = ($urandom_range(0, 9) < 6);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (m_out) begin
      m_lat--;
      if (m_lat == 0) imem_rvalid = 1'b1;
    end
    trap       = ($urandom_range(0, 29) == 0);
    mret       = ($urandom_range(0, 29) == 0);
    br_taken   = ($urandom_range(0, 29) == 0);
    trap_vec   = pick_tgt();
    mepc       = pick_tgt();
    br_target  = pick_tgt();
    inst_ready = ($urandom_range(0, 2) != 0);

    redir = trap | mret | br_taken;
    tgt   = trap ? trap_vec : (mret ? mepc : br_target);
    tgt   = tgt & ~32'h3;

    if (m_hold) begin
      if (redir) begin
        $display("flush   pc %h inst %h -> %h", m_hpc, m_inst, tgt);
        m_hold = 1'b0;
        start_fetch(tgt);
      end else if (inst_ready) begin
        $display("deliver pc %h inst %h", m_hpc, m_inst);
        m_hold = 1'b0;
        start_fetch(m_hpc + 32'd4);
      end
    end else if (m_fetch) begin
      if (redir) begin
        m_pend = 1'b1;
        m_ptgt = tgt;
      end
      if (m_req && imem_gnt) begin
        m_req = 1'b0;
        m_out = 1'b1;
        m_lat = $urandom_range(1, 3);
      end else if (m_out && imem_rvalid) begin
        m_out = 1'b0;
        if (m_pend) begin
          $display("discard pc %h -> %h", m_faddr, m_ptgt);
          start_fetch(m_ptgt);
        end else begin
          m_fetch = 1'b0;
          m_hold  = 1'b1;
          m_inst  = imem_rdata;
          m_hpc   = m_faddr;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    m_fetch = 1'b0; m_req = 1'b0; m_out = 1'b0; m_lat = 0;
    m_faddr = '0; m_pend = 1'b0; m_ptgt = '0;
    m_hold = 1'b0; m_inst = '0; m_hpc = '0;

    reset_start();
    repeat (1500) step();

    // Asynchronous reset while a response is outstanding.
    for (int i = 0; i < 200 && !m_out; i++) step();
    check_eq("reach_wait", m_out, 1'b1);
    reset_start();

    // Asynchronous reset while an instruction is held for decode.
    for (int i = 0; i < 200 && !m_hold; i++) step();
    check_eq("reach_hold", m_hold, 1'b1);
    reset_start();

    // Asynchronous reset while a request is open.
    repeat (20) step();
    for (int i = 0; i < 200 && !m_req; i++) step();
    check_eq("reach_req", m_req, 1'b1);
    reset_start();

    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
